// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches ahead from its own PC and buffers up to DEPTH {pc, ir}
// pairs. A redirect flushes the queue and restarts fetch. At most one icache request is outstanding.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_valid,
  output logic [XLEN-1:0] icache_addr,
  input  logic            icache_ready,
  input  logic [XLEN-1:0] icache_rdata,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_ir,
  output logic [XLEN-1:0] deq_pc,
  output logic [CW-1:0]   count,
  output logic [1:0]      dbg_state_o
);

  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] ir_mem_q [DEPTH];
  logic [XLEN-1:0] redir_pc;
  logic            push, pop, has_room;

  // Handshakes: a request completes on icache_valid & icache_ready; an entry leaves on
  // deq_valid & deq_ready. Both take effect at the clock edge closing that cycle.
  assign redir_pc = redirect_pc & ~XLEN'(3);
  assign pop      = (count_q != '0) && deq_ready;
  assign push     = (state_q == S_REQ) && icache_ready && !redirect_valid;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect_valid) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // A request is only launched when a slot is already free, so completions never overflow.
  assign has_room = count_d < DEPTH_C;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect_valid) fetch_pc_d = redir_pc;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid || has_room) begin
          state_d  = S_REQ;
          req_pc_d = fetch_pc_d;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          if (icache_ready) begin
            state_d  = S_REQ;
            req_pc_d = redir_pc;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (icache_ready) begin
          fetch_pc_d = req_pc_q + STEP;
          if (has_room) begin
            state_d  = S_REQ;
            req_pc_d = req_pc_q + STEP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // The abandoned response is dropped; the latest redirect target is requested next.
        if (icache_ready) begin
          state_d  = S_REQ;
          req_pc_d = fetch_pc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q] <= req_pc_q;
      ir_mem_q[tail_q] <= icache_rdata;
    end
  end

  assign icache_valid = (state_q != S_IDLE);
  assign icache_addr  = req_pc_q;
  assign deq_valid    = (count_q != '0);
  assign deq_pc       = pc_mem_q[head_q];
  assign deq_ir       = ir_mem_q[head_q];
  assign count        = count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a fixed vector table, directed redirect/drain/wrap sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_valid;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_rdata;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_ir;
  logic [31:0] deq_pc;
  logic [2:0]  count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: expected queue contents {pc, ir} and the outstanding request.
  logic [63:0] exp_q[$];
  logic        m_valid;
  logic        m_stale;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_valid(icache_valid), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_ir(deq_ir), .deq_pc(deq_pc), .count(count),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign icache_rdata = mem_word(icache_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid = 1'b0;
    m_stale = 1'b0;
    m_addr  = 32'h0;
    m_fpc   = 32'h0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    icache_ready   = 1'b0;
    deq_ready      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_icache_valid", {31'b0, icache_valid}, 32'h0);
    chk("rst_icache_addr", icache_addr, 32'h0);
    chk("rst_count", {29'b0, count}, 32'h0);
    chk("rst_deq_valid", {31'b0, deq_valid}, 32'h0);
    chk("rst_fsm_idle", {30'b0, dbg_state}, 32'h0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic model_check();
    chk("m_icache_valid", {31'b0, icache_valid}, {31'b0, m_valid});
    if (m_valid) chk("m_icache_addr", icache_addr, m_addr);
    chk("m_count", {29'b0, count}, exp_q.size());
    chk("m_deq_valid", {31'b0, deq_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("m_deq_pc", deq_pc, exp_q[0][63:32]);
      chk("m_deq_ir", deq_ir, exp_q[0][31:0]);
    end
  endtask

  // Spec-level rules: a redirect flushes; a completion of a live request appends
  // {addr, data} and moves the fetch PC on; a new request starts whenever none is
  // outstanding and the queue has a free slot.
  task automatic model_update(input logic redir, input logic [31:0] rpc,
                              input logic rdy, input logic drdy);
    logic comp;
    comp = m_valid && rdy;
    if (redir) begin
      exp_q.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (m_valid && !rdy) begin
        m_stale = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_addr  = m_fpc;
        m_stale = 1'b0;
      end
    end else begin
      if (drdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (comp) begin
        if (!m_stale) begin
          exp_q.push_back({m_addr, mem_word(m_addr)});
          m_fpc = m_addr + 32'd4;
        end
        m_valid = 1'b0;
        m_stale = 1'b0;
      end
      if (!m_valid && exp_q.size() < DEPTH) begin
        m_valid = 1'b1;
        m_addr  = m_fpc;
      end
    end
  endtask

  // Driver: check the current cycle, apply inputs, advance one clock.
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic drdy);
    model_check();
    if (icache_valid && rdy && !redir) begin
      checks++;
      if (count == 3'(DEPTH) && !(deq_valid && drdy)) begin
        errors++;
        $display("FAIL push_into_full actual count=%0d required <%0d", count, DEPTH);
      end
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    icache_ready   = rdy;
    deq_ready      = drdy;
    model_update(redir, rpc, rdy, drdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        drdy;
    logic        ev;
    logic [31:0] ea;
    logic [2:0]  ec;
    logic        edv;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic        redir, rdy, drdy;
    logic [31:0] rpc;
    int          mode;

    // Cache always ready, consumer stalled: fill to DEPTH, then a single pop reopens fetch.
    tbl[0] = '{1'b0, 1'b0, 32'h00, 3'd0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h00, 3'd0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h04, 3'd1, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h08, 3'd2, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h0C, 3'd3, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h00, 3'd4, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h00, 3'd4, 1'b1, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 32'h10, 3'd3, 1'b1, 32'h4};
    tbl[8] = '{1'b0, 1'b0, 32'h00, 3'd4, 1'b1, 32'h4};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl%0d_icache_valid", i), {31'b0, icache_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("tbl%0d_icache_addr", i), icache_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_count", i), {29'b0, count}, {29'b0, tbl[i].ec});
      chk($sformatf("tbl%0d_deq_valid", i), {31'b0, deq_valid}, {31'b0, tbl[i].edv});
      if (tbl[i].edv) begin
        chk($sformatf("tbl%0d_deq_pc", i), deq_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_deq_ir", i), deq_ir, mem_word(tbl[i].epc));
      end
      step(1'b0, 32'h0, 1'b1, tbl[i].drdy);
    end

    // Full throughput: one instruction per cycle, count never above 1.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k >= 2) begin
        chk("thr_deq_valid", {31'b0, deq_valid}, 32'h1);
        chk("thr_deq_pc", deq_pc, 32'(4 * (k - 2)));
      end
      chk("thr_count_le1", {31'b0, count <= 3'd1}, 32'h1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end

    // Three entries queued, redirect while a request is pending, late response drained.
    do_reset();
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drn_count3", {29'b0, count}, 32'h3);
    step(1'b1, 32'h200, 1'b0, 1'b0);
    chk("drn_count0", {29'b0, count}, 32'h0);
    chk("drn_stale_addr", icache_addr, 32'h0C);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drn_after_valid", {31'b0, icache_valid}, 32'h1);
    chk("drn_after_addr", icache_addr, 32'h200);
    chk("drn_after_count", {29'b0, count}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drn_first_deq_pc", deq_pc, 32'h200);

    // Redirect together with a completion and a pop.
    do_reset();
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h80, 1'b1, 1'b1);
    chk("rdr_count0", {29'b0, count}, 32'h0);
    chk("rdr_addr", icache_addr, 32'h80);
    chk("rdr_valid", {31'b0, icache_valid}, 32'h1);

    // Two redirects during a drain: the later one wins.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("two_rdr_stale_addr", icache_addr, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("two_rdr_addr", icache_addr, 32'h300);

    // PC wraps past the top of the address space.
    do_reset();
    step(1'b1, 32'hFFFFFFF8, 1'b0, 1'b1);
    chk("wrap_req_addr", icache_addr, 32'hFFFFFFF8);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc0", deq_pc, 32'hFFFFFFF8);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc1", deq_pc, 32'hFFFFFFFC);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc2", deq_pc, 32'h0);

    // Randomized traffic with consumer phases, unaligned redirects and a mid-run reset.
    do_reset();
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      if (i == 1500) do_reset();
      redir = ($urandom_range(0, 15) == 0);
      rpc   = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      rdy   = icache_valid && ($urandom_range(0, 3) != 0);
      if (mode == 1)      drdy = ($urandom_range(0, 9) == 0);
      else if (mode == 2) drdy = 1'b1;
      else                drdy = 1'($urandom_range(0, 1));
      step(redir, rpc, rdy, drdy);
    end
    model_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
